// File: rtl/fpu_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_collector
// Purpose  : Writeback collection stage of the FPU. Arbitrates the result
//            handshakes of the execution units by fixed priority (index 0
//            highest), buffers the winning result and its destination tag
//            in a 2-entry FIFO, and presents the head entry to register-file
//            writeback. Holds the sticky exception flags (fflags), which
//            accumulate as each result commits (pops) and which software
//            can overwrite through a CSR write port.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            unit_valid/ready     - per-unit result handshake
//            unit_result/flags/
//            unit_rd/unit_rd_int  - per-unit result payload
//            valid_out/ready_in   - writeback handshake
//            result_out/rd_out/
//            rd_int_out           - head entry payload (registered)
//            csr_we/csr_wdata     - fflags write port
//            fflags               - current sticky flags {NV,DZ,OF,UF,NX}
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_collector #(
    parameter int N_UNITS = 4,
    parameter int DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_UNITS-1:0]    unit_valid,
    output logic [N_UNITS-1:0]    unit_ready,
    input  logic [32*N_UNITS-1:0] unit_result,
    input  logic [5*N_UNITS-1:0]  unit_flags,
    input  logic [5*N_UNITS-1:0]  unit_rd,
    input  logic [N_UNITS-1:0]    unit_rd_int,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [31:0]           result_out,
    output logic [4:0]            rd_out,
    output logic                  rd_int_out,
    input  logic                  csr_we,
    input  logic [4:0]            csr_wdata,
    output logic [4:0]            fflags
);

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic [4:0]  rd;
        logic        rd_int;
    } entry_t;

    localparam entry_t c_entry_zero = '0;

    // Storage and control state
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q,  count_d;

    // Registered head copy feeding the outputs
    entry_t      head_q,   head_d;
    logic        valid_q,  valid_d;
    logic [4:0]  fflags_q, fflags_d;

    // Arbitration / handshake wires
    logic [N_UNITS-1:0] grant;
    entry_t             push_entry;
    logic               full;
    logic               push;
    logic               pop;
    logic               found;

    assign full = (count_q == 2'd2);

    // Fixed-priority grant; the same loop captures the winner's payload so
    // no encoded index is needed.
    always_comb begin
        grant      = '0;
        push_entry = c_entry_zero;
        found      = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (unit_valid[i] && !found) begin
                found             = 1'b1;
                grant[i]          = 1'b1;
                push_entry.result = unit_result[32*i +: 32];
                push_entry.flags  = unit_flags[5*i +: 5];
                push_entry.rd     = unit_rd[5*i +: 5];
                push_entry.rd_int = unit_rd_int[i];
            end
        end
    end

    // Ready is gated by reset directly so no unit sees an accept while the
    // FIFO is being cleared asynchronously.
    assign unit_ready = grant & {N_UNITS{!full && !reset}};
    assign push       = |(unit_valid & unit_ready);
    assign pop        = valid_q && ready_in;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        valid_d  = valid_q;
        fflags_d = fflags_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // The head register looks ahead at the next FIFO state so a result
        // pushed at an edge is visible right after that edge. When the FIFO
        // drains, the head keeps its last value (deterministic don't-care).
        valid_d = (count_d != 2'd0);
        if (count_d != 2'd0) begin
            head_d = mem_d[rd_ptr_d];
        end

        // A CSR write replaces the sticky flags but still merges the flags of
        // a result committing in the same cycle.
        if (csr_we) begin
            fflags_d = csr_wdata | (pop ? head_q.flags : 5'd0);
        end else if (pop) begin
            fflags_d = fflags_q | head_q.flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= c_entry_zero;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            head_q   <= c_entry_zero;
            valid_q  <= 1'b0;
            fflags_q <= 5'd0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            fflags_q <= fflags_d;
        end
    end

    assign valid_out  = valid_q;
    assign result_out = head_q.result;
    assign rd_out     = head_q.rd;
    assign rd_int_out = head_q.rd_int;
    assign fflags     = fflags_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_result_collector
// Purpose  : Self-checking bench for fpu_result_collector. A queue-based
//            reference model predicts grants, FIFO contents and fflags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_result_collector;

    localparam int N = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    unit_valid;
    logic [N-1:0]    unit_ready;
    logic [32*N-1:0] unit_result;
    logic [5*N-1:0]  unit_flags;
    logic [5*N-1:0]  unit_rd;
    logic [N-1:0]    unit_rd_int;
    logic            valid_out;
    logic            ready_in;
    logic [31:0]     result_out;
    logic [4:0]      rd_out;
    logic            rd_int_out;
    logic            csr_we;
    logic [4:0]      csr_wdata;
    logic [4:0]      fflags;

    fpu_result_collector #(.N_UNITS(N), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .unit_valid (unit_valid),
        .unit_ready (unit_ready),
        .unit_result(unit_result),
        .unit_flags (unit_flags),
        .unit_rd    (unit_rd),
        .unit_rd_int(unit_rd_int),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .result_out (result_out),
        .rd_out     (rd_out),
        .rd_int_out (rd_int_out),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .fflags     (fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;
        logic [4:0]  rd;
        logic        ri;
    } ent_t;

    ent_t         mq[$];
    logic [4:0]   mflags;
    logic [N-1:0] last_ready;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec rule: lowest valid index wins, nothing accepted when 2 results are held.
    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (mq.size() < 2) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (unit_valid[i]) r = logic'(1) << i;
            end
        end
        return r;
    endfunction

    task automatic set_unit(input int i, input logic v, input logic [31:0] r,
                            input logic [4:0] f, input logic [4:0] d, input logic ri);
        unit_valid[i]         = v;
        unit_result[32*i +: 32] = r;
        unit_flags[5*i +: 5]  = f;
        unit_rd[5*i +: 5]     = d;
        unit_rd_int[i]        = ri;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        logic [N-1:0] er;
        logic         pop;
        ent_t         e;
        #1;
        er = exp_ready();
        last_ready = unit_ready;
        chk("unit_ready", {28'd0, unit_ready}, {28'd0, er});
        @(posedge clk);
        pop = (mq.size() > 0) && ready_in;
        if (csr_we)   mflags = csr_wdata | (pop ? mq[0].fl : 5'd0);
        else if (pop) mflags = mflags | mq[0].fl;
        if (pop) void'(mq.pop_front());
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                e.res = unit_result[32*i +: 32];
                e.fl  = unit_flags[5*i +: 5];
                e.rd  = unit_rd[5*i +: 5];
                e.ri  = unit_rd_int[i];
                mq.push_back(e);
            end
        end
        @(negedge clk);
        chk("valid_out", {31'd0, valid_out}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("result_out", result_out, mq[0].res);
            chk("rd_out", {27'd0, rd_out}, {27'd0, mq[0].rd});
            chk("rd_int_out", {31'd0, rd_int_out}, {31'd0, mq[0].ri});
        end
        chk("fflags", {27'd0, fflags}, {27'd0, mflags});
    endtask

    task automatic drain();
        unit_valid = '0;
        csr_we     = 1'b0;
        ready_in   = 1'b1;
        for (int k = 0; k < 3; k++) tick();
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_rdy;
    } prio_vec_t;

    prio_vec_t pv[8];

    initial begin
        pv[0] = '{4'b0000, 4'b0000};
        pv[1] = '{4'b0001, 4'b0001};
        pv[2] = '{4'b1010, 4'b0010};
        pv[3] = '{4'b0110, 4'b0010};
        pv[4] = '{4'b1100, 4'b0100};
        pv[5] = '{4'b1000, 4'b1000};
        pv[6] = '{4'b1111, 4'b0001};
        pv[7] = '{4'b0101, 4'b0001};

        reset       = 1'b1;
        unit_valid  = '1;
        unit_result = '0;
        unit_flags  = '0;
        unit_rd     = '0;
        unit_rd_int = '0;
        ready_in    = 1'b0;
        csr_we      = 1'b0;
        csr_wdata   = '0;
        mflags      = '0;
        last_ready  = '0;

        // Reset state
        #1;
        chk("ready_in_reset", {28'd0, unit_ready}, 32'd0);
        unit_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_result_out", result_out, 32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        chk("rst_rd_int_out", {31'd0, rd_int_out}, 32'd0);
        chk("rst_fflags", {27'd0, fflags}, 32'd0);
        @(negedge clk);

        // Priority table, FIFO empty; valids withdrawn before the edge
        for (int v = 0; v < 8; v++) begin
            unit_valid = pv[v].valid;
            #1;
            chk("prio_table", {28'd0, unit_ready}, {28'd0, pv[v].exp_rdy});
            unit_valid = '0;
            @(negedge clk);
        end

        // Single unit push and commit
        ready_in = 1'b1;
        set_unit(1, 1'b1, 32'h4B00_0001, 5'b00001, 5'd7, 1'b0);
        tick();
        chk("single_ready", {28'd0, last_ready}, 32'h2);
        chk("single_result", result_out, 32'h4B00_0001);
        chk("single_rd", {27'd0, rd_out}, 32'd7);
        unit_valid = '0;
        tick();
        chk("single_fflags", {27'd0, fflags}, 32'h1);
        drain();

        // Priority between units 0 and 2
        set_unit(0, 1'b1, 32'hAAAA_0000, 5'b00000, 5'd1, 1'b0);
        set_unit(2, 1'b1, 32'hCCCC_0002, 5'b00100, 5'd3, 1'b1);
        tick();
        chk("prio_first_ready", {28'd0, last_ready}, 32'h1);
        chk("prio_first_out", result_out, 32'hAAAA_0000);
        unit_valid[0] = 1'b0;
        tick();
        chk("prio_second_ready", {28'd0, last_ready}, 32'h4);
        chk("prio_second_out", result_out, 32'hCCCC_0002);
        unit_valid[2] = 1'b0;
        drain();

        // Full / backpressure
        ready_in = 1'b0;
        set_unit(3, 1'b1, 32'h1111_1111, 5'b00001, 5'd10, 1'b0);
        tick();
        set_unit(3, 1'b1, 32'h2222_2222, 5'b00010, 5'd11, 1'b1);
        tick();
        set_unit(3, 1'b1, 32'h3333_3333, 5'b01000, 5'd12, 1'b0);
        tick();
        chk("full_ready", {28'd0, last_ready}, 32'h0);
        tick();
        ready_in = 1'b1;
        tick();
        chk("full_second_head", result_out, 32'h2222_2222);
        for (int k = 0; k < 2; k++) begin
            if (last_ready[3]) unit_valid[3] = 1'b0;
            tick();
        end
        chk("full_third_head", result_out, 32'h3333_3333);
        drain();

        // Sustained streaming from count 1, then from full
        ready_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_unit(1, 1'b1, 32'h5000_0000 + k, 5'(k), 5'(k), k[0]);
            tick();
            chk("stream_ready", {28'd0, last_ready}, 32'h2);
        end
        unit_valid = '0;
        ready_in   = 1'b0;
        set_unit(2, 1'b1, 32'h6000_0001, 5'b0, 5'd2, 1'b0);
        tick();
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_unit(2, 1'b1, 32'h6100_0000 + k, 5'b0, 5'd4, 1'b1);
            tick();
        end
        drain();

        // CSR write racing a commit
        csr_we    = 1'b1;
        csr_wdata = 5'b10000;
        tick();
        csr_we   = 1'b0;
        ready_in = 1'b0;
        set_unit(0, 1'b1, 32'h7777_7777, 5'b00101, 5'd9, 1'b0);
        tick();
        unit_valid = '0;
        ready_in   = 1'b1;
        csr_we     = 1'b1;
        csr_wdata  = 5'b00000;
        tick();
        chk("csr_race", {27'd0, fflags}, 32'h5);
        csr_we = 1'b0;
        drain();

        // Randomized traffic honouring the hold-until-granted protocol
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!unit_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_unit(i, 1'b1, $urandom,
                             (i == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom),
                             5'($urandom), 1'($urandom));
                end
            end
            ready_in  = ($urandom_range(0, 3) != 0);
            csr_we    = ($urandom_range(0, 15) == 0);
            csr_wdata = 5'($urandom);
            tick();
            unit_valid = unit_valid & ~last_ready;
        end
        drain();

        // Mid-operation asynchronous reset with two entries held
        csr_we    = 1'b1;
        csr_wdata = 5'b11111;
        tick();
        csr_we   = 1'b0;
        ready_in = 1'b0;
        set_unit(1, 1'b1, 32'h8888_0001, 5'b0, 5'd1, 1'b0);
        tick();
        set_unit(1, 1'b1, 32'h8888_0002, 5'b0, 5'd2, 1'b0);
        tick();
        set_unit(3, 1'b1, 32'h9999_0003, 5'b00010, 5'd3, 1'b1);
        unit_valid[1] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("mid_rst_fflags", {27'd0, fflags}, 32'd0);
        chk("mid_rst_ready", {28'd0, unit_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        mflags = '0;
        tick();
        chk("post_rst_push", result_out, 32'h9999_0003);
        unit_valid = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
